seq_gen: RTL and testbench

Serial pattern transmitter: the source end of the single-bit `d` stream consumed by the `seq` sequence detector. On a `start` request it captures a P_W-bit pattern and shifts it out MSB-first on `d`, repeating it `reps` times with `gap` idle cycles between repetitions, then pulses `done`. It drives detector benches and link stimulus from RTL rather than hand-written delays.

---
 rtl/seq_gen.sv | 115 +++++++++++
 tb/tb_seq_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a captured P_W-bit pattern out MSB-first,
// repeated `reps` times with `gap` idle cycles between copies, then pulses done.
module seq_gen #(
  parameter int P_W = 4,
  parameter int C_W = 4,
  parameter int G_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [P_W-1:0] pat,
  input  logic [C_W-1:0] reps,
  input  logic [G_W-1:0] gap,
  output logic           d,
  output logic           vld,
  output logic           busy,
  output logic           done
);

  localparam int IW = $clog2(P_W);
  localparam logic [IW-1:0] IDX_TOP = IW'(P_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t         state_q, state_d;
  logic [P_W-1:0] pat_q, pat_d;
  logic [C_W-1:0] rep_q, rep_d;
  logic [G_W-1:0] gap_q, gap_d;
  logic [G_W-1:0] gcnt_q, gcnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           d_q, d_d, vld_q, vld_d, busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = pat;
          rep_d   = reps;
          gap_d   = gap;
          idx_d   = IDX_TOP;
          state_d = (reps != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (idx_q == '0) begin
          // End of one copy: rep_q still counts the copy just finished.
          rep_d = rep_q - 1'b1;
          idx_d = IDX_TOP;
          if (rep_q == C_W'(1)) begin
            state_d = DONE;
          end else if (gap_q != '0) begin
            state_d = GAP;
            gcnt_d  = gap_q;
          end else begin
            state_d = SEND;
          end
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      GAP: begin
        if (gcnt_q == G_W'(1)) state_d = SEND;
        else                   gcnt_d  = gcnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered images of the current state, so they trail it by one edge.
  always_comb begin
    d_d    = (state_q == SEND) & pat_q[idx_q];
    vld_d  = (state_q == SEND);
    busy_d = (state_q == SEND) | (state_q == GAP);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      d_q     <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign d    = d_q;
  assign vld  = vld_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: queue-based expected-output model checked every cycle,
// plus directed scenarios with literal bit strings and timing.
module tb_seq_gen;
  localparam int P_W = 4, C_W = 4, G_W = 3;

  logic           clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [P_W-1:0] pat = '0;
  logic [C_W-1:0] reps = '0;
  logic [G_W-1:0] gap = '0;
  logic           d, vld, busy, done;

  seq_gen #(.P_W(P_W), .C_W(C_W), .G_W(G_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pat(pat), .reps(reps), .gap(gap),
    .d(d), .vld(vld), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = -1, done_cyc = -1, vrise_cyc = -1;
  int vcnt = 0, busy_cnt = 0, done_cnt = 0;
  logic [63:0] dlog = '0;
  logic prev_vld = 1'b0;
  logic [3:0] q[$];   // expected {d,vld,busy,done} for upcoming edges
  logic [3:0] exp_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: a transmission is a list of per-cycle outputs built from the
  // request; a new start is taken only once the previous list is exhausted.
  always @(posedge clk) begin
    bit was_empty;
    cyc++;
    if (!rst) begin
      q.delete();
      exp_o = '0;
    end else begin
      was_empty = (q.size() == 0);
      exp_o = was_empty ? 4'b0000 : q.pop_front();
      if (was_empty && start) begin
        acc_cyc = cyc;
        for (int r = 0; r < int'(reps); r++) begin
          for (int b = P_W - 1; b >= 0; b--) q.push_back({pat[b], 3'b110});
          if (r < int'(reps) - 1)
            for (int g = 0; g < int'(gap); g++) q.push_back(4'b0010);
        end
        q.push_back(4'b0001);
      end
    end
    #1;
    check("outputs", {60'd0, d, vld, busy, done}, {60'd0, exp_o});
    if (vld) begin dlog = {dlog[62:0], d}; vcnt++; end
    if (vld && !prev_vld) vrise_cyc = cyc;
    prev_vld = vld;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic clr();
    dlog = '0; vcnt = 0; busy_cnt = 0; done_cnt = 0;
    done_cyc = -1; acc_cyc = -1; vrise_cyc = -1;
  endtask

  task automatic go(input logic [P_W-1:0] p, input logic [C_W-1:0] r, input logic [G_W-1:0] g);
    @(negedge clk);
    pat = p; reps = r; gap = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int i;
    for (i = 0; i < budget && done_cnt < n; i++) @(negedge clk);
    check("done_seen", 64'(done_cnt >= n), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", {60'd0, d, vld, busy, done}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single copy, no gap.
    clr(); go(4'b1001, 1, 0); wait_done(1, 40);
    check("t1_bits", dlog[3:0], 64'b1001);
    check("t1_vcnt", vcnt, 4);
    check("t1_busy", busy_cnt, 4);
    check("t1_done_lat", done_cyc - acc_cyc, 5);
    check("t1_done_cnt", done_cnt, 1);

    // Three copies separated by two idle cycles.
    clr(); go(4'b1001, 3, 2); wait_done(1, 60);
    check("t2_bits", dlog[11:0], 64'b1001_1001_1001);
    check("t2_busy", busy_cnt, 16);
    check("t2_done_lat", done_cyc - acc_cyc, 17);

    // Back-to-back copies.
    clr(); go(4'b1011, 2, 0); wait_done(1, 40);
    check("t3_bits", dlog[7:0], 64'b1011_1011);
    check("t3_busy", busy_cnt, 8);
    check("t3_done_lat", done_cyc - acc_cyc, 9);

    // Inputs changed and start pulsed mid-transmission: ignored.
    clr(); go(4'b1001, 2, 0);
    @(negedge clk); pat = 4'b0110; reps = 4'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(1, 40);
    repeat (6) @(negedge clk);
    check("t4_bits", dlog[7:0], 64'b1001_1001);
    check("t4_vcnt", vcnt, 8);
    check("t4_done_cnt", done_cnt, 1);

    // Start held high: one idle cycle between done and next first bit.
    clr();
    @(negedge clk); pat = 4'b1101; reps = 1; gap = 0; start = 1'b1;
    wait_done(1, 40);
    check("t5_restart", vrise_cyc - done_cyc, 2);
    start = 1'b0;
    wait_done(2, 40);
    check("t5_bits", dlog[7:0], 64'b1101_1101);

    // reps = 0: done only.
    clr(); go(4'b1111, 0, 3); wait_done(1, 20);
    check("t6_vcnt", vcnt, 0);
    check("t6_busy", busy_cnt, 0);
    check("t6_done_lat", done_cyc - acc_cyc, 1);

    // Maximum gap.
    clr(); go(4'b0101, 2, 7); wait_done(1, 60);
    check("t7_bits", dlog[7:0], 64'b0101_0101);
    check("t7_busy", busy_cnt, 15);
    check("t7_done_lat", done_cyc - acc_cyc, 16);

    // Asynchronous reset mid-SEND, between edges.
    clr(); go(4'b1111, 5, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", {60'd0, d, vld, busy, done}, 64'd0);
    @(negedge clk); rst = 1'b1;
    clr();
    repeat (12) @(negedge clk);
    check("post_reset_vcnt", vcnt, 0);
    check("post_reset_done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
